// File: rtl/transport_block_scheduler.sv
// -----------------------------------------------------------------------------
// transport_block_scheduler
//
// Round-robin arbiter that cuts byte streams from N_SRC requesters into fixed
// transport blocks of SIZE_TBLCK bytes. A granted source owns the whole block.
// If the source runs dry for TIME_TO_WAIT consecutive requested cycles, the
// rest of the block is padded with 8'h00.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   src_val       per-source byte valid
//   src_data      per-source byte, source i at [8i+7:8i]
//   src_req       per-source read strobe (consume = src_req & src_val)
//   ireq          downstream request for one byte
//   oval, odata   output byte valid / data
//   ogrant        index of the source owning the current block
//   osob, oeob    start / end of block markers, qualified by oval
//   pad_cnt       (TBSCHED_PAD_CNT_EN only) saturating count of PAD transfers
//
// Optional feature macro: TBSCHED_PAD_CNT_EN
// -----------------------------------------------------------------------------
module transport_block_scheduler #(
    parameter int N_SRC        = 4,
    parameter int SIZE_TBLCK   = 480,
    parameter int TIME_TO_WAIT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_SRC-1:0]           src_val,
    input  logic [8*N_SRC-1:0]         src_data,
    output logic [N_SRC-1:0]           src_req,
    input  logic                       ireq,
    output logic                       oval,
    output logic [7:0]                 odata,
    output logic [$clog2(N_SRC)-1:0]   ogrant,
    output logic                       osob,
`ifdef TBSCHED_PAD_CNT_EN
    output logic                       oeob,
    output logic [15:0]                pad_cnt
`else
    output logic                       oeob
`endif
);

    localparam int G_W    = $clog2(N_SRC);
    localparam int CNT_W  = $clog2(SIZE_TBLCK);
    localparam int WAIT_W = $clog2(TIME_TO_WAIT + 1);

    typedef enum logic [1:0] {IDLE, SEND, PAD} state_t;

    state_t             state, state_nxt;
    logic [G_W-1:0]     grant, grant_nxt;
    logic [G_W-1:0]     last_grant, last_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [WAIT_W-1:0]  wcnt, wcnt_nxt;
    logic [G_W-1:0]     rr_pick, idx;
    logic               xfer;

    // Round-robin pick: scan from last_grant+N down to last_grant+1 so the
    // closest valid source after last_grant is the final (winning) write.
    always_comb begin
        rr_pick = last_grant;
        idx     = '0;
        for (int k = N_SRC; k >= 1; k--) begin
            idx = G_W'((int'(last_grant) + k) % N_SRC);
            if (src_val[idx]) rr_pick = idx;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last_grant;
        cnt_nxt   = cnt;
        wcnt_nxt  = wcnt;
        oval      = 1'b0;
        odata     = 8'h00;
        src_req   = '0;
        xfer      = 1'b0;

        case (state)
            IDLE: begin
                if (|src_val) begin
                    grant_nxt = rr_pick;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                oval         = src_val[grant];
                odata        = src_data[8*grant +: 8];
                src_req[grant] = ireq;
                xfer         = ireq & src_val[grant];
                // Only requested-but-starved cycles advance the wait counter.
                if (xfer) begin
                    wcnt_nxt = '0;
                end else if (ireq) begin
                    if (wcnt == WAIT_W'(TIME_TO_WAIT - 1)) begin
                        state_nxt = PAD;
                        wcnt_nxt  = '0;
                    end else begin
                        wcnt_nxt = wcnt + 1'b1;
                    end
                end
            end
            PAD: begin
                oval = 1'b1;
                xfer = ireq;
            end
            default: state_nxt = IDLE;
        endcase

        if (xfer) begin
            if (cnt == CNT_W'(SIZE_TBLCK - 1)) begin
                cnt_nxt   = '0;
                last_nxt  = grant;
                state_nxt = IDLE;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end

        // Silence the outputs during reset so nothing is consumed or emitted
        // in the cycle the block is abandoned.
        if (rst) begin
            oval    = 1'b0;
            odata   = 8'h00;
            src_req = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= G_W'(N_SRC - 1);
            cnt        <= '0;
            wcnt       <= '0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_nxt;
            cnt        <= cnt_nxt;
            wcnt       <= wcnt_nxt;
        end
    end

    assign ogrant = grant;
    assign osob   = oval & (cnt == '0);
    assign oeob   = oval & (cnt == CNT_W'(SIZE_TBLCK - 1));

`ifdef TBSCHED_PAD_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            pad_cnt <= '0;
        else if (state == PAD && ireq && pad_cnt != 16'hFFFF)
            pad_cnt <= pad_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_transport_block_scheduler.sv
module tb_transport_block_scheduler;

    localparam int N   = 4;
    localparam int SZ  = 480;
    localparam int G_W = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   src_val;
    logic [8*N-1:0] src_data;
    logic [N-1:0]   src_req;
    logic           ireq = 1'b0;
    logic           oval;
    logic [7:0]     odata;
    logic [G_W-1:0] ogrant;
    logic           osob, oeob;
`ifdef TBSCHED_PAD_CNT_EN
    logic [15:0]    pad_cnt;
`endif

    transport_block_scheduler #(.N_SRC(N), .SIZE_TBLCK(SZ), .TIME_TO_WAIT(16)) dut (
        .clk(clk), .rst(rst), .src_val(src_val), .src_data(src_data),
        .src_req(src_req), .ireq(ireq), .oval(oval), .odata(odata),
        .ogrant(ogrant), .osob(osob),
`ifdef TBSCHED_PAD_CNT_EN
        .oeob(oeob), .pad_cnt(pad_cnt)
`else
        .oeob(oeob)
`endif
    );

    always #5 clk = ~clk;

    // Source model: source i emits byte (seq+64*i) while seq < limit.
    int         seq [N];
    int         limit [N];
    logic [N-1:0] ven = '0;
    logic       seq_clr = 1'b1;

    always_comb begin
        src_val  = '0;
        src_data = '0;
        for (int i = 0; i < N; i++) begin
            src_val[i]        = ven[i] && (seq[i] < limit[i]);
            src_data[8*i +: 8] = 8'((seq[i] + 64*i) & 255);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (seq_clr) seq[i] <= 0;
            else if (src_req[i] && src_val[i]) seq[i] <= seq[i] + 1;
        end
    end

    typedef struct packed {
        logic [G_W-1:0] g;
        logic [7:0]     d;
        logic           sob;
        logic           eob;
        logic           pad;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   starve = 0;
    int   starve_at_eob = -1;
    int   eob_cyc = -1000;
    int   gap = -1;

    task automatic push_block(input int g, input int start, input int nreal);
        exp_t e;
        for (int n = 0; n < SZ; n++) begin
            e.g   = G_W'(g);
            e.pad = (n >= nreal);
            e.d   = e.pad ? 8'h00 : 8'((start + n + 64*g) & 255);
            e.sob = (n == 0);
            e.eob = (n == SZ-1);
            q.push_back(e);
        end
    endtask

    task automatic monitor();
        exp_t e;
        logic [N-1:0] req_exp;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (ireq && !oval) starve++;
                if (ireq && oval) begin
                    checks++;
                    if (q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_xfer got g=%0d d=%h sob=%b eob=%b, required no transfer",
                                 ogrant, odata, osob, oeob);
                    end else begin
                        e = q.pop_front();
                        if ({ogrant, odata, osob, oeob} !== {e.g, e.d, e.sob, e.eob}) begin
                            failures++;
                            $display("FAIL xfer got g=%0d d=%h sob=%b eob=%b, required g=%0d d=%h sob=%b eob=%b",
                                     ogrant, odata, osob, oeob, e.g, e.d, e.sob, e.eob);
                        end
                        req_exp = e.pad ? '0 : (N'(1) << e.g);
                        checks++;
                        if (src_req !== req_exp) begin
                            failures++;
                            $display("FAIL src_req got %b required %b", src_req, req_exp);
                        end
                    end
                    if (osob) begin
                        gap    = cyc - eob_cyc;
                        starve = 0;
                    end
                    if (oeob) begin
                        eob_cyc       = cyc;
                        starve_at_eob = starve;
                    end
                end
            end
        end
    endtask

    task automatic wait_size(input int sz, input int budget);
        int n = 0;
        while (q.size() > sz && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (q.size() > sz) begin
            failures++;
            $display("FAIL timeout queue=%0d required<=%0d", q.size(), sz);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; seq_clr = 1'b1;
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; seq_clr = 1'b0;
    endtask

    task automatic test_reset();
        ven = '0; ireq = 1'b0; rst = 1'b1;
        for (int i = 0; i < N; i++) limit[i] = 100000;
        repeat (3) @(posedge clk);
        #1; ven = '1; ireq = 1'b1;
        @(negedge clk);
        checks++;
        if ({oval, src_req, odata, osob, oeob, ogrant} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got oval=%b req=%b d=%h sob=%b eob=%b g=%0d required all 0",
                     oval, src_req, odata, osob, oeob, ogrant);
        end
`ifdef TBSCHED_PAD_CNT_EN
        checks++;
        if (pad_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_pad_cnt got %0d required 0", pad_cnt);
        end
`endif
        ven = '0; ireq = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        ven = 4'b0001; limit[0] = 100000; ireq = 1'b1;
        push_block(0, 0, SZ);
        push_block(0, SZ, SZ);
        wait_size(0, 3000);
        checks++;
        if (gap !== 2) begin
            failures++;
            $display("FAIL block_gap got %0d required 2", gap);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        ven = 4'b1111; ireq = 1'b1;
        for (int i = 0; i < N; i++) limit[i] = 100000;
        for (int b = 0; b < 4; b++) push_block(b, 0, SZ);
        push_block(0, SZ, SZ);
        wait_size(0, 6000);
    endtask

    task automatic test_pad();
        do_reset();
        ven = 4'b0010; limit[1] = 100; ireq = 1'b1;
        push_block(1, 0, 100);
        wait_size(300, 1000);
        // Source comes back while padding; its bytes must stay unread.
        limit[1] = 1000;
        wait_size(0, 1000);
        checks++;
        if (starve_at_eob !== 16) begin
            failures++;
            $display("FAIL pad_starve got %0d required 16", starve_at_eob);
        end
        checks++;
        if (seq[1] !== 100) begin
            failures++;
            $display("FAIL pad_consumed got %0d required 100", seq[1]);
        end
`ifdef TBSCHED_PAD_CNT_EN
        checks++;
        if (pad_cnt !== 16'd380) begin
            failures++;
            $display("FAIL pad_cnt got %0d required 380", pad_cnt);
        end
`endif
    endtask

    task automatic test_ireq_hold();
        do_reset();
        ven = 4'b0001; limit[0] = 50; ireq = 1'b1;
        push_block(0, 0, SZ);
        wait_size(SZ-50, 500);
        repeat (6) @(posedge clk);
        #1 ireq = 1'b0;
        repeat (50) @(posedge clk);
        #1 ireq = 1'b1;
        repeat (6) @(posedge clk);
        #1 limit[0] = 100000;
        wait_size(0, 1000);
        checks++;
        if (starve_at_eob !== 11) begin
            failures++;
            $display("FAIL hold_starve got %0d required 11", starve_at_eob);
        end
    endtask

    task automatic test_rst_mid();
        int start;
        do_reset();
        ven = 4'b0011; limit[0] = 100000; limit[1] = 100000; ireq = 1'b1;
        push_block(0, 0, SZ);
        wait_size(SZ-200, 1000);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (oval !== 1'b0 || src_req !== '0) begin
            failures++;
            $display("FAIL rst_mid got oval=%b req=%b required 0/0", oval, src_req);
        end
        q.delete();
        start = seq[0];
        push_block(0, start, SZ);
        @(posedge clk); #1 rst = 1'b0;
        wait_size(0, 1000);
    endtask

    initial begin
        fork monitor(); join_none
        test_reset();
        test_single();
        test_round_robin();
        test_pad();
        test_ireq_hold();
        test_rst_mid();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
